// File: rtl/tanh_arb.sv
// tanh_arb: shares one pipelined tanh engine among NREQ requesters and tags each result with its
// originating requester ID. Define TANH_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module tanh_arb #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned TAGQ_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [14*NREQ-1:0]      i_req_x,
    input  logic [NREQ-1:0]         i_req_valid,
    output logic [NREQ-1:0]         o_req_ready,
    output logic [13:0]             o_eng_x,
    output logic                    o_eng_valid,
    input  logic                    i_eng_ready,
    input  logic [13:0]             i_eng_fx,
    input  logic                    i_eng_valid,
    output logic                    o_eng_ready,
    output logic [13:0]             o_fx,
    output logic [$clog2(NREQ)-1:0] o_id,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_err
);
    localparam int unsigned IdW  = $clog2(NREQ);
    localparam int unsigned PtrW = (TAGQ_DEPTH > 1) ? $clog2(TAGQ_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(TAGQ_DEPTH + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(TAGQ_DEPTH - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(TAGQ_DEPTH);

    logic [13:0]     req_x [NREQ];
    logic [IdW-1:0]  grant_id;
    logic [IdW-1:0]  cand;
    logic            issue;
    logic            pop;
    logic            empty;
    logic            full;

    logic [IdW-1:0]  tagq_mem [TAGQ_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            err_q, err_d;

    for (genvar r = 0; r < NREQ; r++) begin : g_unpack
        assign req_x[r] = i_req_x[14*r +: 14];
    end

`ifndef TANH_ARB_FIXED_PRIO_EN
    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
`endif

    // Scan from the highest offset down so the lowest offset with a valid request wins.
    always_comb begin
        grant_id = '0;
        cand     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef TANH_ARB_FIXED_PRIO_EN
            cand = IdW'(k);
`else
            cand = rr_ptr_q + IdW'(k);
`endif
            if (i_req_valid[cand]) begin
                grant_id = cand;
            end
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CntFull);

    // Gated by rst_n so nothing is offered to the engine while the block is held in reset.
    assign o_eng_valid = rst_n & (|i_req_valid) & ~full;
    assign o_eng_x     = req_x[grant_id];
    assign issue       = o_eng_valid & i_eng_ready;
    assign o_req_ready = issue ? (NREQ'(1) << grant_id) : '0;

    assign pop         = i_eng_valid & i_ready & ~empty;
    assign o_eng_ready = i_ready;
    assign o_fx        = i_eng_fx;
    assign o_valid     = i_eng_valid;
    assign o_id        = (rst_n && !empty) ? tagq_mem[rd_ptr_q] : '0;
    assign o_err       = err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (issue) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end
        if (issue && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !issue) begin
            count_d = count_q - 1'b1;
        end
    end

    // A result handshake with no outstanding ID is a protocol violation by the engine.
    assign err_d = err_q | (i_eng_valid & i_ready & empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            tagq_mem[wr_ptr_q] <= grant_id;
        end
    end

`ifndef TANH_ARB_FIXED_PRIO_EN
    assign rr_ptr_d = issue ? grant_id + 1'b1 : rr_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

endmodule

// File: tb/tb_tanh_arb.sv
// tb_tanh_arb: drives tanh_arb with a latency-L elastic tanh engine model and checks it against a
// request/ID scoreboard, hand vector tables and directed corner sequences.
module tb_tanh_arb;
    localparam int L     = 3;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [55:0] req_x = '0;
    logic [3:0]  req_v = '0;
    logic [3:0]  req_rdy;
    logic [13:0] eng_x;
    logic        eng_v;
    logic        eng_rdy = 1'b1;
    logic [13:0] eng_fx;
    logic        eng_out_v;
    logic        eng_out_rdy;
    logic [13:0] o_fx;
    logic [1:0]  o_id;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic        o_err;
    logic        inj_v = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    tanh_arb #(.NREQ(4), .TAGQ_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_x     (req_x),
        .i_req_valid (req_v),
        .o_req_ready (req_rdy),
        .o_eng_x     (eng_x),
        .o_eng_valid (eng_v),
        .i_eng_ready (eng_rdy),
        .i_eng_fx    (eng_fx),
        .i_eng_valid (eng_out_v),
        .o_eng_ready (eng_out_rdy),
        .o_fx        (o_fx),
        .o_id        (o_id),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_err       (o_err)
    );

    function automatic logic [13:0] tanh_q(input logic [13:0] x);
        real r;
        real t;
        int  v;
        r = real'($signed(x)) / 4096.0;
        t = $tanh(r) * 4096.0;
        v = $rtoi((t >= 0.0) ? t + 0.5 : t - 0.5);
        return v[13:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Engine model: elastic buffer, each result becomes visible L cycles after acceptance.
    logic [13:0] e_fx [64];
    int          e_t  [64];
    int          eh = 0;
    int          et = 0;
    int          cyc = 0;
    logic        e_v;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eh <= 0;
            et <= 0;
        end else begin
            if (e_v && eng_out_rdy) eh <= eh + 1;
            if (eng_v && eng_rdy) begin
                e_fx[et % 64] <= tanh_q(eng_x);
                e_t[et % 64]  <= cyc + L;
                et            <= et + 1;
            end
        end
    end

    always_comb begin
        e_v = (eh != et) && (cyc >= e_t[eh % 64]);
    end
    assign eng_out_v = e_v | inj_v;
    assign eng_fx    = inj_v ? 14'h0 : e_fx[eh % 64];

    // Scoreboard: expected grant from the arbitration rule, expected IDs/results in issue order.
    int          m_rr = 0;
    bit          m_err = 1'b0;
    int          m_id [$];
    logic [13:0] m_fx [$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_rr  = 0;
                m_err = 1'b0;
                m_id.delete();
                m_fx.delete();
                chk("rst_req_ready", req_rdy, 0);
                chk("rst_eng_valid", eng_v, 0);
                chk("rst_o_id", o_id, 0);
                chk("rst_o_valid", o_valid, 0);
            end else begin
                int eg;
                eg = -1;
                if (req_v != 0 && m_id.size() < DEPTH) begin
                    for (int k = 3; k >= 0; k--) begin
                        int r;
`ifdef TANH_ARB_FIXED_PRIO_EN
                        r = k;
`else
                        r = (m_rr + k) % 4;
`endif
                        if (req_v[r]) eg = r;
                    end
                end
                chk("req_ready", req_rdy, (eg >= 0 && eng_rdy) ? (32'd1 << eg) : 32'd0);
                chk("eng_valid", eng_v, (eg >= 0) ? 1 : 0);
                if (eg >= 0) chk("eng_x", eng_x, req_x[14*eg +: 14]);
                chk("eng_ready_fwd", eng_out_rdy, i_ready);
                chk("o_err", o_err, m_err);
                chk("o_id", o_id, (m_id.size() != 0) ? m_id[0] : 0);
                if (o_valid && m_id.size() != 0) chk("o_fx", o_fx, m_fx[0]);
                if (o_valid && i_ready) begin
                    if (m_id.size() == 0) begin
                        m_err = 1'b1;
                    end else begin
                        void'(m_id.pop_front());
                        void'(m_fx.pop_front());
                    end
                end
                if (eg >= 0 && eng_rdy) begin
                    m_id.push_back(eg);
                    m_fx.push_back(tanh_q(req_x[14*eg +: 14]));
                    m_rr = (eg + 1) % 4;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic [3:0] v;
        logic [3:0] rr;
        logic [3:0] fp;
    } vec_t;

    vec_t tbl [10];
    bit   found;

    initial begin
        tbl[0] = '{4'b1111, 4'b0001, 4'b0001};
        tbl[1] = '{4'b1111, 4'b0010, 4'b0001};
        tbl[2] = '{4'b0001, 4'b0001, 4'b0001};
        tbl[3] = '{4'b1001, 4'b1000, 4'b0001};
        tbl[4] = '{4'b1001, 4'b0001, 4'b0001};
        tbl[5] = '{4'b0000, 4'b0000, 4'b0000};
        tbl[6] = '{4'b0110, 4'b0010, 4'b0010};
        tbl[7] = '{4'b0110, 4'b0100, 4'b0010};
        tbl[8] = '{4'b0011, 4'b0001, 4'b0001};
        tbl[9] = '{4'b1000, 4'b1000, 4'b1000};

        req_x = {14'h0400, 14'h0300, 14'h0200, 14'h0100};
        step(3);
        rst_n = 1'b1;
        chk("reset_err", o_err, 0);

        // Grant sequence from the reset pointer.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 req_v = tbl[i].v;
            @(negedge clk);
`ifdef TANH_ARB_FIXED_PRIO_EN
            chk("tbl_grant", req_rdy, tbl[i].fp);
`else
            chk("tbl_grant", req_rdy, tbl[i].rr);
`endif
        end
        step(1);
        req_v = 4'b0000;
        step(10);

        // All requesters valid continuously.
        do_reset();
        req_v = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
`ifdef TANH_ARB_FIXED_PRIO_EN
            chk("all_valid_grant", req_rdy, 4'b0001);
`else
            chk("all_valid_grant", req_rdy, 32'd1 << (i % 4));
`endif
            step(1);
        end
        req_v = 4'b0000;
        step(10);

        // Single requester 2 with x = 0.25.
        req_x[41:28] = 14'h0400;
        req_v = 4'b0100;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("req2_grant", req_rdy, 4'b0100);
            if (o_valid && !found) begin
                chk("req2_id", o_id, 2);
                chk("req2_fx", o_fx, 14'd1003);
                found = 1'b1;
            end
            step(1);
        end
        chk("req2_result_seen", found, 1);
        req_v = 4'b0000;
        step(10);

        // Downstream stall fills the ID queue.
        req_v = 4'b1111;
        i_ready = 1'b0;
        step(20);
        @(negedge clk);
        chk("full_eng_valid", eng_v, 0);
        chk("full_req_ready", req_rdy, 0);
        chk("full_outstanding", et - eh, DEPTH);
        step(1);
        i_ready = 1'b1;
        req_v = 4'b0000;
        step(40);
        @(negedge clk);
        #1;
        chk("drain_scoreboard", m_id.size(), 0);
        chk("drain_engine", et - eh, 0);

        // Result with nothing outstanding.
        step(1);
        inj_v = 1'b1;
        step(1);
        inj_v = 1'b0;
        step(3);
        @(negedge clk);
        chk("err_set", o_err, 1);
        step(1);
        req_v = 4'b1111;
        step(5);
        req_v = 4'b0000;
        step(10);
        @(negedge clk);
        chk("err_sticky", o_err, 1);
        do_reset();
        @(negedge clk);
        chk("err_cleared", o_err, 0);

        // Reset with 10 IDs outstanding.
        step(1);
        i_ready = 1'b0;
        req_v = 4'b0010;
        step(10);
        req_v = 4'b0000;
        chk("pre_rst_outstanding", et - eh, 10);
        req_v = 4'b1111;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        i_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", req_rdy, 4'b0001);
        step(1);
        req_v = 4'b0000;
        step(10);

`ifdef TANH_ARB_FIXED_PRIO_EN
        req_v = 4'b1001;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("fixed_prio_grant", req_rdy, 4'b0001);
            step(1);
        end
        req_v = 4'b0000;
        step(10);
`endif

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            req_v   = 4'($urandom());
            req_x   = {24'($urandom()), $urandom()};
            i_ready = ($urandom_range(0, 3) != 0);
            eng_rdy = ($urandom_range(0, 4) != 0);
            step(1);
        end
        req_v   = 4'b0000;
        i_ready = 1'b1;
        eng_rdy = 1'b1;
        step(40);
        @(negedge clk);
        #1;
        chk("rand_drain_scoreboard", m_id.size(), 0);
        chk("rand_no_err", o_err, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
